// File: rtl/bru_pkg.sv
// Shared definitions for branch resolution:
// condition codes, FSM states and ROB age helper.
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    // Distance of a tag from the ROB head; smaller means older.
    // Tags are passed widened to 32 bits.
    function automatic logic [31:0] rob_age(
        input logic [31:0] tag,
        input logic [31:0] head,
        input logic [31:0] depth
    );
        return (tag - head) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: funct3 and operands to taken.
// Purely combinational so the ALU can share it.
module branch_cmp
    import bru_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken
);

    // Decode the condition; reserved encodings never branch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves executed branches, reports to the ROB and holds
// a redirect for the oldest outstanding mispredict.
module branch_resolve
    import bru_pkg::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [TAG_W-1:0] ex_rob_tag,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_rs1_val,
    input  logic [31:0]      ex_rs2_val,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm_b,
    input  logic             ex_pred_taken,
    input  logic [TAG_W-1:0] rob_head_tag,
    input  logic             rob_retire_valid,
    input  logic [TAG_W-1:0] rob_retire_tag,
    input  logic             flush_in,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_rob_tag,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [31:0]      redir_pc,
    output logic [TAG_W-1:0] redir_rob_tag,
    output logic             busy
);

    localparam logic [31:0] DEPTH = 32'(ROB_DEPTH);

    state_t           state;
    state_t           state_nx;
    logic             capture;
    logic             taken;
    logic             mispredict;
    logic [31:0]      target;
    logic [31:0]      age_in;
    logic [31:0]      age_held;
    logic [31:0]      age_bnd;
    logic             squashed;
    logic             older_than_held;
    logic             handshake;
    logic             bnd_valid;
    logic [TAG_W-1:0] bnd_tag;

    branch_cmp u_cmp (
        .funct3 (ex_funct3),
        .rs1    (ex_rs1_val),
        .rs2    (ex_rs2_val),
        .taken  (taken)
    );

    assign target = taken ? (ex_pc + ex_imm_b) : (ex_pc + 32'd4);
    assign mispredict = ex_valid & (taken ^ ex_pred_taken);

    assign age_in   = rob_age(32'(ex_rob_tag), 32'(rob_head_tag), DEPTH);
    assign age_held = rob_age(32'(redir_rob_tag), 32'(rob_head_tag), DEPTH);
    assign age_bnd  = rob_age(32'(bnd_tag), 32'(rob_head_tag), DEPTH);

    assign squashed        = bnd_valid && (age_in > age_bnd);
    assign older_than_held = age_in < age_held;
    assign handshake       = (state == PEND) && redir_ready;

    assign redir_valid = (state == PEND);
    assign busy        = (state == PEND) || bnd_valid;

    // State register; flush and reset both return to IDLE.
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and capture decision for the held redirect.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (mispredict && !squashed) begin
                    capture  = 1'b1;
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (redir_ready) begin
                    if (mispredict && older_than_held) begin
                        capture = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (mispredict && !squashed && older_than_held) begin
                    capture = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result stage and redirect holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid      <= 1'b0;
            res_rob_tag    <= '0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
            redir_pc       <= '0;
            redir_rob_tag  <= '0;
        end else begin
            res_valid <= ex_valid && !flush_in;
            if (ex_valid) begin
                res_rob_tag    <= ex_rob_tag;
                res_taken      <= taken;
                res_mispredict <= taken ^ ex_pred_taken;
            end
            if (capture && !flush_in) begin
                redir_pc      <= target;
                redir_rob_tag <= ex_rob_tag;
            end
        end
    end

    // Squash boundary: set on handshake, cleared on its retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            bnd_valid <= 1'b0;
            bnd_tag   <= '0;
        end else if (flush_in) begin
            bnd_valid <= 1'b0;
        end else if (handshake) begin
            bnd_valid <= 1'b1;
            bnd_tag   <= redir_rob_tag;
        end else if (rob_retire_valid && rob_retire_tag == bnd_tag) begin
            bnd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve.
// Inputs change #1 after posedge, outputs sampled there too.
module tb_branch_resolve;
    import bru_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ex_valid = 1'b0;
    logic [TAG_W-1:0] ex_rob_tag = '0;
    logic [2:0]       ex_funct3 = '0;
    logic [31:0]      ex_rs1_val = '0;
    logic [31:0]      ex_rs2_val = '0;
    logic [31:0]      ex_pc = '0;
    logic [31:0]      ex_imm_b = '0;
    logic             ex_pred_taken = 1'b0;
    logic [TAG_W-1:0] rob_head_tag = '0;
    logic             rob_retire_valid = 1'b0;
    logic [TAG_W-1:0] rob_retire_tag = '0;
    logic             flush_in = 1'b0;
    logic             res_valid;
    logic [TAG_W-1:0] res_rob_tag;
    logic             res_taken;
    logic             res_mispredict;
    logic             redir_valid;
    logic             redir_ready = 1'b0;
    logic [31:0]      redir_pc;
    logic [TAG_W-1:0] redir_rob_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve #(.ROB_DEPTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_rob_tag       (ex_rob_tag),
        .ex_funct3        (ex_funct3),
        .ex_rs1_val       (ex_rs1_val),
        .ex_rs2_val       (ex_rs2_val),
        .ex_pc            (ex_pc),
        .ex_imm_b         (ex_imm_b),
        .ex_pred_taken    (ex_pred_taken),
        .rob_head_tag     (rob_head_tag),
        .rob_retire_valid (rob_retire_valid),
        .rob_retire_tag   (rob_retire_tag),
        .flush_in         (flush_in),
        .res_valid        (res_valid),
        .res_rob_tag      (res_rob_tag),
        .res_taken        (res_taken),
        .res_mispredict   (res_mispredict),
        .redir_valid      (redir_valid),
        .redir_ready      (redir_ready),
        .redir_pc         (redir_pc),
        .redir_rob_tag    (redir_rob_tag),
        .busy             (busy)
    );

    task automatic br(input logic [3:0] tag, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic pred);
        ex_valid      = 1'b1;
        ex_rob_tag    = tag;
        ex_funct3     = f3;
        ex_rs1_val    = a;
        ex_rs2_val    = b;
        ex_pc         = pc;
        ex_imm_b      = imm;
        ex_pred_taken = pred;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ex_valid         = 1'b0;
        rob_retire_valid = 1'b0;
        redir_ready      = 1'b0;
        flush_in         = 1'b0;
    endtask

    task automatic retire(input logic [3:0] tag);
        rob_retire_valid = 1'b1;
        rob_retire_tag   = tag;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({res_valid, res_taken, res_mispredict, redir_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {res_valid, res_taken, res_mispredict, redir_valid, busy});
        end
        checks++;
        if ({redir_pc, redir_rob_tag, res_rob_tag} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0",
                     {redir_pc, redir_rob_tag, res_rob_tag});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_beq();
        rob_head_tag = 4'd0;
        br(4'd1, F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        tick();
        checks++;
        if ({res_valid, res_taken, res_mispredict, res_rob_tag} !== {3'b111, 4'd1}) begin
            errors++;
            $display("FAIL beq_res got %b%b%b tag %0d exp 111 tag 1",
                     res_valid, res_taken, res_mispredict, res_rob_tag);
        end
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h120 || busy !== 1'b1) begin
            errors++;
            $display("FAIL beq_redir got v%b pc %h busy %b exp v1 pc 120 busy 1",
                     redir_valid, redir_pc, busy);
        end
        tick();
        tick();
        tick();
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h120 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL beq_hold got v%b pc %h res %b exp v1 pc 120 res 0",
                     redir_valid, redir_pc, res_valid);
        end
        redir_ready = 1'b1;
        tick();
        checks++;
        if (redir_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL beq_accept got v%b busy %b exp v0 busy 1",
                     redir_valid, busy);
        end
        retire(4'd1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL beq_retire busy got %b exp 0", busy);
        end
    endtask

    task automatic test_signed();
        br(4'd2, F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
        tick();
        checks++;
        if (res_taken !== 1'b1 || res_mispredict !== 1'b0 || redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL blt got t%b m%b v%b exp t1 m0 v0",
                     res_taken, res_mispredict, redir_valid);
        end
        br(4'd3, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
        tick();
        checks++;
        if (res_taken !== 1'b0 || res_mispredict !== 1'b1 || redir_pc !== 32'h204) begin
            errors++;
            $display("FAIL bltu got t%b m%b pc %h exp t0 m1 pc 204",
                     res_taken, res_mispredict, redir_pc);
        end
        redir_ready = 1'b1;
        tick();
        retire(4'd3);
        br(4'd4, 3'b010, 32'd0, 32'd0, 32'h300, 32'h8, 1'b0);
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b0 || redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_f3 got r%b t%b v%b exp r1 t0 v0",
                     res_valid, res_taken, redir_valid);
        end
        br(4'd5, F3_BNE, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0);
        tick();
        checks++;
        if (redir_pc !== 32'h10 || redir_rob_tag !== 4'd5) begin
            errors++;
            $display("FAIL wrap_pc got %h tag %0d exp 10 tag 5",
                     redir_pc, redir_rob_tag);
        end
        redir_ready = 1'b1;
        tick();
        retire(4'd5);
    endtask

    task automatic test_oldest();
        rob_head_tag = 4'd14;
        br(4'd2, F3_BEQ, 32'd1, 32'd1, 32'h1000, 32'h10, 1'b0);
        tick();
        br(4'd15, F3_BGE, 32'd3, 32'd3, 32'h2000, 32'h30, 1'b0);
        tick();
        checks++;
        if (redir_rob_tag !== 4'd15 || redir_pc !== 32'h2030 || redir_valid !== 1'b1) begin
            errors++;
            $display("FAIL older_replace got tag %0d pc %h exp 15 2030",
                     redir_rob_tag, redir_pc);
        end
        br(4'd3, F3_BGEU, 32'd0, 32'd9, 32'h3000, 32'h8, 1'b1);
        tick();
        checks++;
        if (redir_rob_tag !== 4'd15 || redir_pc !== 32'h2030 || res_mispredict !== 1'b1) begin
            errors++;
            $display("FAIL younger_kept got tag %0d pc %h m%b exp 15 2030 m1",
                     redir_rob_tag, redir_pc, res_mispredict);
        end
        redir_ready = 1'b1;
        tick();
        retire(4'd15);
        rob_head_tag = 4'd0;
    endtask

    task automatic test_boundary();
        br(4'd5, F3_BEQ, 32'd7, 32'd7, 32'h500, 32'h40, 1'b0);
        tick();
        redir_ready = 1'b1;
        tick();
        br(4'd7, F3_BEQ, 32'd7, 32'd7, 32'h700, 32'h40, 1'b0);
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_mispredict !== 1'b1 || redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash got r%b m%b v%b exp r1 m1 v0",
                     res_valid, res_mispredict, redir_valid);
        end
        retire(4'd5);
        br(4'd9, F3_BEQ, 32'd7, 32'd7, 32'h900, 32'h40, 1'b0);
        tick();
        checks++;
        if (redir_valid !== 1'b1 || redir_rob_tag !== 4'd9 || redir_pc !== 32'h940) begin
            errors++;
            $display("FAIL post_retire got v%b tag %0d pc %h exp v1 9 940",
                     redir_valid, redir_rob_tag, redir_pc);
        end
        redir_ready = 1'b1;
        br(4'd4, F3_BNE, 32'd1, 32'd1, 32'h400, 32'h40, 1'b1);
        tick();
        checks++;
        if (redir_valid !== 1'b1 || redir_rob_tag !== 4'd4 || redir_pc !== 32'h404) begin
            errors++;
            $display("FAIL hs_capture got v%b tag %0d pc %h exp v1 4 404",
                     redir_valid, redir_rob_tag, redir_pc);
        end
        redir_ready = 1'b1;
        tick();
        retire(4'd4);
        checks++;
        if (busy !== 1'b0 || redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL bnd_clear got busy %b v%b exp 0 0", busy, redir_valid);
        end
    endtask

    task automatic test_flush();
        br(4'd3, F3_BEQ, 32'd1, 32'd1, 32'h600, 32'h10, 1'b0);
        tick();
        flush_in = 1'b1;
        br(4'd2, F3_BEQ, 32'd1, 32'd1, 32'h680, 32'h10, 1'b0);
        tick();
        checks++;
        if (redir_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush got v%b r%b busy %b exp 0 0 0",
                     redir_valid, res_valid, busy);
        end
    endtask

    task automatic test_rst_mid();
        br(4'd6, F3_BEQ, 32'd2, 32'd2, 32'h800, 32'h10, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({res_valid, res_taken, res_mispredict, redir_valid, busy} !== 5'b0 ||
            {redir_pc, redir_rob_tag, res_rob_tag} !== 40'h0) begin
            errors++;
            $display("FAIL rst_mid got %b %h exp all zero",
                     {res_valid, res_taken, res_mispredict, redir_valid, busy},
                     {redir_pc, redir_rob_tag, res_rob_tag});
        end
        rst = 1'b0;
        br(4'd6, F3_BNE, 32'd1, 32'd2, 32'h40, 32'h8, 1'b0);
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1 || redir_pc !== 32'h48 ||
            redir_rob_tag !== 4'd6) begin
            errors++;
            $display("FAIL rst_after got r%b t%b pc %h tag %0d exp 1 1 48 6",
                     res_valid, res_taken, redir_pc, redir_rob_tag);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_beq();
        test_signed();
        test_oldest();
        test_boundary();
        test_flush();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
